// File: rtl/ppu_ri_pkg.sv
// -----------------------------------------------------------------------------
// ppu_ri_pkg
// Shared definitions for the PPU register-interface initiator:
//   - register-select constants for 0x2000..0x2007
//   - FSM state encoding (IDLE/SETUP/ACCESS/RECOVER)
//   - default /CS timing and fill-length width
// -----------------------------------------------------------------------------
package ppu_ri_pkg;

    // PPU register selects (CPU address 0x2000 + sel)
    localparam logic [2:0] RI_SEL_PPUCTRL   = 3'd0;
    localparam logic [2:0] RI_SEL_PPUMASK   = 3'd1;
    localparam logic [2:0] RI_SEL_PPUSTATUS = 3'd2;
    localparam logic [2:0] RI_SEL_OAMADDR   = 3'd3;
    localparam logic [2:0] RI_SEL_OAMDATA   = 3'd4;
    localparam logic [2:0] RI_SEL_PPUSCROLL = 3'd5;
    localparam logic [2:0] RI_SEL_PPUADDR   = 3'd6;
    localparam logic [2:0] RI_SEL_PPUDATA   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } ri_state_e;

    // Default /CS low and high phase lengths in clk cycles
    localparam int DEF_CS_LOW_CYCLES  = 4;
    localparam int DEF_CS_HIGH_CYCLES = 4;

    // Width of the fill repeat count
    localparam int RI_LEN_W = 11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ppu_ri_initiator_if.sv
// -----------------------------------------------------------------------------
// ppu_ri_initiator_if
// Request/response bundle between the CPU bus decode (master) and the
// ppu_ri_initiator (slave).
//   req_valid/req_ready  : request handshake
//   req_sel/req_r_nw     : register select and direction (1=read)
//   req_wdata            : write data
//   req_fill/req_len     : repeat-write request (only with PPU_RI_FILL_EN)
//   rsp_valid/rsp_rdata  : completion pulse and read data
// Optional feature macro: PPU_RI_FILL_EN
// -----------------------------------------------------------------------------
interface ppu_ri_initiator_if;
    import ppu_ri_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_sel;
    logic                req_r_nw;
    logic [7:0]          req_wdata;
`ifdef PPU_RI_FILL_EN
    logic                req_fill;
    logic [RI_LEN_W-1:0] req_len;
`endif
    logic                rsp_valid;
    logic [7:0]          rsp_rdata;

`ifdef PPU_RI_FILL_EN
    modport master (
        output req_valid, req_sel, req_r_nw, req_wdata, req_fill, req_len,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_sel, req_r_nw, req_wdata, req_fill, req_len,
        output req_ready, rsp_valid, rsp_rdata
    );
`else
    modport master (
        output req_valid, req_sel, req_r_nw, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_sel, req_r_nw, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
`endif

endinterface

// File: rtl/ppu_ri_phase_cnt.sv
// -----------------------------------------------------------------------------
// ppu_ri_phase_cnt
// Loadable down-counter timing the ACCESS and RECOVER phases. It stops at
// zero (no wrap) and flags when it is there.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (has priority over counting)
//   load_val   : value to load (phase length - 1)
//   zero       : counter is 0, i.e. the current cycle is the last of a phase
// -----------------------------------------------------------------------------
module ppu_ri_phase_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: registers are written with <= so every flop samples the values
    // from before the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ppu_ri_initiator.sv
// -----------------------------------------------------------------------------
// ppu_ri_initiator
// CPU-side initiator for the PPU register interface. Each accepted request
// becomes one /CS-low pulse (ri_ncs) framed by a one-cycle setup and a
// recovery gap, so the PPU sees exactly one falling edge per access.
//   clk, rst_n : 50 MHz clock, asynchronous active-low reset
//   host       : request/response interface (slave side)
//   busy       : FSM is not in IDLE
//   ri_sel     : register select to the PPU
//   ri_ncs     : active-low chip select to the PPU
//   ri_r_nw    : 1=read, 0=write, to the PPU
//   ri_dout    : write data to the PPU
//   ri_din     : read data from the PPU
// Optional feature macro: PPU_RI_FILL_EN (repeat-write "fill" requests that
// issue req_len ACCESS/RECOVER pairs with the same sel/data).
// Reads of PPUDATA return the PPU's buffered value unmodified.
// -----------------------------------------------------------------------------
module ppu_ri_initiator
    import ppu_ri_pkg::*;
#(
    parameter int CS_LOW_CYCLES  = DEF_CS_LOW_CYCLES,
    parameter int CS_HIGH_CYCLES = DEF_CS_HIGH_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    ppu_ri_initiator_if.slave   host,
    output logic                busy,
    output logic [2:0]          ri_sel,
    output logic                ri_ncs,
    output logic                ri_r_nw,
    output logic [7:0]          ri_dout,
    input  logic [7:0]          ri_din
);

    localparam int CNT_W = $clog2(max_int(CS_LOW_CYCLES, CS_HIGH_CYCLES) + 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(CS_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(CS_HIGH_CYCLES - 1);

    ri_state_e        state;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;

    // Repeat bookkeeping: rep_none = nothing to send (zero-length fill),
    // rep_last = the current ACCESS is the final one, rep_more = another
    // ACCESS follows the current RECOVER.
    logic rep_none;
    logic rep_last;
    logic rep_more;

`ifdef PPU_RI_FILL_EN
    // Accesses still to finish; decremented at the end of each ACCESS.
    logic [RI_LEN_W-1:0] remaining;

    assign rep_none = (remaining == '0);
    assign rep_last = (remaining == RI_LEN_W'(1));
    assign rep_more = (remaining != '0);
`else
    assign rep_none = 1'b0;
    assign rep_last = 1'b1;
    assign rep_more = 1'b0;
`endif

    assign host.req_ready = (state == ST_IDLE);
    assign busy           = (state != ST_IDLE);

    // Counter is loaded on the cycle before each ACCESS or RECOVER phase.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = LOW_LOAD;
        case (state)
            ST_SETUP:   cnt_load = !rep_none;
            ST_ACCESS: begin
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = HIGH_LOAD;
                end
            end
            ST_RECOVER: cnt_load = cnt_zero && rep_more;
            default:    cnt_load = 1'b0;
        endcase
    end

    ppu_ri_phase_cnt #(
        .W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            ri_ncs         <= 1'b1;
            ri_r_nw        <= 1'b1;
            ri_sel         <= 3'd0;
            ri_dout        <= 8'd0;
            host.rsp_valid <= 1'b0;
            host.rsp_rdata <= 8'd0;
`ifdef PPU_RI_FILL_EN
            remaining      <= '0;
`endif
        end else begin
            host.rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (host.req_valid) begin
                        ri_sel  <= host.req_sel;
                        ri_r_nw <= host.req_r_nw;
                        ri_dout <= host.req_wdata;
                        state   <= ST_SETUP;
`ifdef PPU_RI_FILL_EN
                        if (host.req_fill) begin
                            ri_r_nw   <= 1'b0;
                            remaining <= host.req_len;
                            // A zero-length fill completes from SETUP.
                            if (host.req_len == '0) begin
                                host.rsp_valid <= 1'b1;
                            end
                        end else begin
                            remaining <= RI_LEN_W'(1);
                        end
`endif
                    end
                end
                ST_SETUP: begin
                    if (rep_none) begin
                        state   <= ST_IDLE;
                        ri_r_nw <= 1'b1;
                    end else begin
                        state  <= ST_ACCESS;
                        ri_ncs <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_zero) begin
                        state  <= ST_RECOVER;
                        ri_ncs <= 1'b1;
                        if (ri_r_nw) begin
                            host.rsp_rdata <= ri_din;
                        end
                        if (rep_last) begin
                            host.rsp_valid <= 1'b1;
                        end
`ifdef PPU_RI_FILL_EN
                        remaining <= remaining - RI_LEN_W'(1);
`endif
                    end
                end
                ST_RECOVER: begin
                    if (cnt_zero) begin
                        if (rep_more) begin
                            state  <= ST_ACCESS;
                            ri_ncs <= 1'b0;
                        end else begin
                            state   <= ST_IDLE;
                            ri_r_nw <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
